display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexing scheduler that shares the single BCD-to-seven-segment decoder between the digits of a multi-digit display. It snapshots a packed BCD value once per frame and steps through the digits in turn, presenting each nibble to the decoder and enabling that digit's common line. A blanking guard interval between digits prevents ghosting. It sits between the counter datapath, which produces the BCD value, and the decoder and display pins.

## Interface
- DIGITS, 4, number of display digits (≥2)
- SCAN_DIV, 50000, clock cycles per digit slot
- BLANK_CYCLES, 500, guard cycles at the start of each slot with all digits off (1 ≤ BLANK_CYCLES < SCAN_DIV)

- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- en  in  1  scan enable; low forces the display dark and idle
- lz_blank  in  1  leading-zero blanking enable
- value  in  4*DIGITS  packed BCD; nibble i is digit i; digit 0 is least significant
- bcd  out  4  nibble routed to the shared decoder
- digit_en  out  DIGITS  one-hot, active-high digit common enable
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken

## Operation
- States:
  - IDLE: all outputs 0; slot counter and digit index cleared.
  - BLANK: digit_en = 0; bcd = current digit's nibble.
  - DRIVE: digit_en[idx] = 1 unless the digit is suppressed.
- Transitions:
  - IDLE→BLANK when en=1. This cycle loads `snap <= value`, sets idx=0 and pulses frame_start.
  - BLANK→DRIVE after BLANK_CYCLES cycles in BLANK.
  - DRIVE→BLANK after SCAN_DIV−BLANK_CYCLES cycles in DRIVE, with idx+1.
  - When idx=DIGITS−1 and DRIVE ends: idx wraps to 0 and the transition reloads snap and pulses frame_start, exactly as at frame start.
- en=0 in any state → IDLE on the next edge. The current slot is abandoned, with no completion.
- Snapshot rule: value is sampled only on frame_start cycles. Changes mid-frame never tear the displayed number.
- Leading-zero suppression (lz_blank=1): digit i is suppressed if snap nibbles DIGITS−1 down to i are all zero and i≠0. Digit 0 is always shown.
- Suppression is evaluated from snap, not from live value.
- Nibbles >9 are passed through unchanged; the decoder defines their glyph.
- Slot counter width is clog2(SCAN_DIV). It counts 0..SCAN_DIV−1 and wraps per slot; it never overflows.

## Timing
- Reset (rst=1 at an edge): state IDLE, bcd=0, digit_en=0, frame_start=0, snap=0, idx=0, counter=0. rst has priority over en.
- Outputs are decoded only from registered state, snap, idx and counter. There is no combinational path from any input to any output.
- Latency: en rising at edge k puts the block in BLANK after edge k. frame_start is high for that cycle, and digit_en[0] first asserts BLANK_CYCLES cycles later.
- Frame period: exactly DIGITS*SCAN_DIV cycles. frame_start spacing equals the frame period while en stays high.
- digit_en is never multi-hot. Between any two different digits there are at least BLANK_CYCLES all-zero cycles.
- bcd changes only at BLANK entry, never during DRIVE.
- en dropping during DRIVE: digit_en reaches 0 on the next cycle.

## Structure
- Shared package display_pkg holds:
  - state enum scan_state_t {IDLE, BLANK, DRIVE};
  - BCD nibble width constant (4);
  - function for the leading-zero mask.
- One sub-module is natural: scan_prescaler, a slot counter with blank_done and slot_done outputs.
- The FSM, snapshot register and digit mux live in the top module.

## Test plan
The bench uses DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
- Reset then en=1, value=16'h1234:
  - frame_start one cycle after en is sampled;
  - digit_en sequence 0001 (bcd 4), 0010 (3), 0100 (2), 1000 (1), each high for 6 cycles after 2 dark cycles;
  - frame_start repeats every 32 cycles.
- lz_blank=1, value=16'h0050: digits 0 and 1 show 0 and 5; digit_en stays 0 during slots 2 and 3. With value=16'h0000, only digit 0 lights, with bcd=0.
- value changes from 16'h1234 to 16'h5678 in the middle of slot 1: the remainder of the frame still shows 3, 2, 1; the next frame shows 8, 7, 6, 5.
- en dropped during DRIVE of digit 2: all outputs 0 the next cycle. When en is reasserted, a frame restarts at digit 0 with a new snapshot.
- rst asserted mid-frame with en=1: IDLE and all-zero outputs on the following cycle. After rst is released, the frame restarts at digit 0.
- Assertion over the whole run:
  - digit_en is one-hot or zero;
  - at least 2 zero cycles between distinct digits;
  - bcd is stable while any digit_en bit is high.

Source files
------------

// File: rtl/display_scan_controller_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the multiplexed seven-segment display scanner.
//   scan_state_t   : scan FSM states (IDLE, BLANK, DRIVE)
//   BCD_W          : width of one BCD nibble
//   MAX_DIGITS     : largest digit count the helper function handles
//   lz_digit_shown : leading-zero suppression decision for one digit
// ---------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 16;
    localparam int LZ_VALUE_W = BCD_W * MAX_DIGITS;

    // A digit is shown when blanking is off, when it is digit 0, or when it
    // or any more significant digit (below n) holds a non-zero nibble.
    function automatic logic lz_digit_shown(
        input logic [LZ_VALUE_W-1:0] v,
        input int                    digit,
        input int                    n,
        input logic                  lz
    );
        logic any_nonzero;
        any_nonzero = 1'b0;
        for (int j = 0; j < MAX_DIGITS; j++) begin
            if ((j >= digit) && (j < n) && (v[j*BCD_W +: BCD_W] != '0)) begin
                any_nonzero = 1'b1;
            end
        end
        return (!lz) || (digit == 0) || any_nonzero;
    endfunction

endpackage

// File: rtl/display_scan_controller_scan_prescaler.sv
// ---------------------------------------------------------------------------
// scan_prescaler
// Per-slot cycle counter for the display scanner. Counts 0..SCAN_DIV-1 while
// run is high and wraps at the end of each slot; held at 0 while run is low.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   run        : count enable; low clears the counter
//   blank_done : high on the last guard cycle of the slot
//   slot_done  : high on the last cycle of the slot
// ---------------------------------------------------------------------------
module scan_prescaler
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic blank_done,
    output logic slot_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    assign blank_done = (count_reg == BLANK_LAST);
    assign slot_done  = (count_reg == SLOT_LAST);

    always_comb begin
        count_next = count_reg + CW'(1);
        if (!run || slot_done) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// ---------------------------------------------------------------------------
// display_scan_controller
// Time-multiplexes one BCD-to-seven-segment decoder across DIGITS digits.
// A packed BCD value (and the leading-zero setting) is captured once per
// frame; each digit slot starts with BLANK_CYCLES dark cycles, then lights
// that digit's common line for the rest of the slot.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   en          : scan enable; low forces everything dark and idle
//   lz_blank    : leading-zero blanking enable (captured at frame start)
//   value       : packed BCD, nibble i is digit i (digit 0 least significant)
//   bcd         : nibble presented to the shared decoder
//   digit_en    : one-hot active-high digit common enables
//   frame_start : one-cycle pulse in the cycle after a snapshot is taken
// All outputs decode from registers only.
// ---------------------------------------------------------------------------
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    lz_blank,
    input  logic [BCD_W*DIGITS-1:0] value,
    output logic [BCD_W-1:0]        bcd,
    output logic [DIGITS-1:0]       digit_en,
    output logic                    frame_start
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    scan_state_t             state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [BCD_W*DIGITS-1:0] snap_reg, snap_next;
    logic                    lz_snap_reg, lz_snap_next;
    logic                    frame_start_reg, frame_start_next;

    logic                    blank_done;
    logic                    slot_done;
    logic                    prescale_run;
    logic [LZ_VALUE_W-1:0]   snap_ext;
    logic [BCD_W-1:0]        nibble [DIGITS];
    logic [DIGITS-1:0]       shown;

    // The counter only runs while a slot is in progress, so it is already
    // zero on the first BLANK cycle of a fresh frame.
    assign prescale_run = en && (state_reg != IDLE);

    scan_prescaler #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .run        (prescale_run),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        snap_next        = snap_reg;
        lz_snap_next     = lz_snap_reg;
        frame_start_next = 1'b0;
        if (!en) begin
            state_next = IDLE;
            idx_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next       = BLANK;
                    idx_next         = '0;
                    snap_next        = value;
                    lz_snap_next     = lz_blank;
                    frame_start_next = 1'b1;
                end
                BLANK: begin
                    if (blank_done) begin
                        state_next = DRIVE;
                    end
                end
                DRIVE: begin
                    if (slot_done) begin
                        state_next = BLANK;
                        if (idx_reg == IDX_LAST) begin
                            // Frame boundary: new snapshot, same as frame start.
                            idx_next         = '0;
                            snap_next        = value;
                            lz_snap_next     = lz_blank;
                            frame_start_next = 1'b1;
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            snap_reg        <= '0;
            lz_snap_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            snap_reg        <= snap_next;
            lz_snap_reg     <= lz_snap_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign snap_ext = LZ_VALUE_W'(snap_reg);

    // Per-digit nibble extraction, suppression and common-line decode.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign nibble[gi]   = snap_reg[gi*BCD_W +: BCD_W];
        assign shown[gi]    = lz_digit_shown(snap_ext, gi, DIGITS, lz_snap_reg);
        assign digit_en[gi] = (state_reg == DRIVE) && (idx_reg == IDX_W'(gi)) && shown[gi];
    end

    // idx and snap only change on BLANK entry, so bcd is steady through DRIVE.
    assign bcd         = (state_reg == IDLE) ? '0 : nibble[idx_reg];
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        lz_blank = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  bcd;
    logic [3:0]  digit_en;
    logic        frame_start;

    display_scan_controller #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .lz_blank    (lz_blank),
        .value       (value),
        .bcd         (bcd),
        .digit_en    (digit_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fs;
        logic [3:0] den;
        logic [3:0] nib;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   started  = 0;

    // Expected outputs for position t (cycles since the frame's snapshot).
    function automatic exp_t model_out(bit active, int t, logic [15:0] snap, bit lz);
        exp_t e;
        int   slot;
        int   phase;
        bit   shown;
        e = '0;
        if (active) begin
            slot  = t / SCAN_DIV;
            phase = t % SCAN_DIV;
            shown = !lz || (slot == 0) || ((snap >> (4 * slot)) != 16'h0);
            e.fs  = (t == 0);
            e.nib = 4'((snap >> (4 * slot)) & 16'hF);
            if (phase >= BLANK_CYCLES && shown) e.den = 4'(1 << slot);
        end
        return e;
    endfunction

    task automatic check(string name, logic [3:0] act, logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s time=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Reference model: frame position advances by one per cycle while enabled.
    initial begin : model
        bit          active;
        int          t;
        logic [15:0] snap;
        bit          lzs;
        active = 0; t = 0; snap = '0; lzs = 0;
        forever begin
            @(posedge clk);
            if (rst || !en) begin
                active = 0;
            end else if (!active) begin
                active = 1; t = 0; snap = value; lzs = lz_blank;
            end else begin
                t++;
                if (t == FRAME) begin
                    t = 0; snap = value; lzs = lz_blank;
                end
            end
            exp_q.push_back(model_out(active, t, snap, lzs));
            started = 1;
        end
    end

    // Monitor: compares each presented cycle against the scoreboard and
    // checks the global display invariants.
    initial begin : monitor
        exp_t       e;
        logic [3:0] prev_den;
        logic [3:0] prev_bcd;
        logic [3:0] last_lit;
        int         zero_run;
        prev_den = '0; prev_bcd = '0; last_lit = '0; zero_run = 100;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                if (started) begin
                    checks++; failures++;
                    $display("FAIL queue_underflow time=%0t actual=empty required=entry", $time);
                end
            end else begin
                e = exp_q.pop_front();
                check("frame_start", {3'b0, frame_start}, {3'b0, e.fs});
                check("digit_en", digit_en, e.den);
                check("bcd", bcd, e.nib);
            end
            checks++;
            if (!$onehot0(digit_en)) begin
                failures++;
                $display("FAIL onehot0 time=%0t actual=%b required=onehot_or_zero", $time, digit_en);
            end
            if (prev_den != 0 && digit_en != 0) check("bcd_stable", bcd, prev_bcd);
            if (digit_en != 0) begin
                if (last_lit != 0 && digit_en != last_lit) begin
                    checks++;
                    if (zero_run < BLANK_CYCLES) begin
                        failures++;
                        $display("FAIL guard_gap time=%0t actual=%0d required=%0d", $time, zero_run, BLANK_CYCLES);
                    end
                end
                last_lit = digit_en;
                zero_run = 0;
            end else begin
                zero_run++;
            end
            prev_den = digit_en;
            prev_bcd = bcd;
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        rst = 1; step(3);
        rst = 0; step(2);
        // Plain scan, then a mid-frame value change during slot 1.
        value = 16'h1234; en = 1; step(12);
        value = 16'h5678; step(60);
        // Leading-zero blanking.
        en = 0; step(1);
        value = 16'h0050; lz_blank = 1; en = 1; step(34);
        value = 16'h0000; step(36);
        // en dropped during DRIVE of digit 2, then restarted with nibbles > 9.
        en = 0; lz_blank = 0; value = 16'h1234; step(1);
        en = 1; step(19);
        en = 0; step(3);
        value = 16'h9abc; en = 1; step(40);
        // Reset mid-frame with en held high.
        step(13);
        rst = 1; step(1);
        rst = 0; step(40);
        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) value = 16'($urandom);
            if ($urandom_range(0, 29) == 0) lz_blank = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) en = ~en;
            rst = ($urandom_range(0, 199) == 0);
            step(1);
        end
        rst = 0; en = 1; step(40);
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
